// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder; the single arithmetic cell
// through which every bit of the serial addition passes.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: computes a+b+cin LSB first, one bit per clock, through one
// full_adder_cell. Defining SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;

    full_adder_cell u_cell (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // The MSB is being added on the edge where the counter reads WIDTH-1.
    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Result bits enter from the MSB side so the LSB lands in bit 0 after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): a driver issues additions,
// a scoreboard queue holds expected results and timing, a monitor compares.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             dut_ovf;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    // Expected {ovf, cout, sum}, accept cycle and done cycle per addition.
    logic [WIDTH+1:0] exp_q[$];
    int               acc_q[$];
    int               done_q[$];
    logic [WIDTH+1:0] last_res = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .cout  (cout),
        .ovf   (dut_ovf)
`else
        .cout  (cout)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign dut_ovf = 1'b0;
`endif

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain integer addition and sign rules.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                                input logic [WIDTH-1:0] mb,
                                                input logic mc);
        int unsigned total;
        logic [WIDTH:0] full;
        logic v;
        total = int'(ma) + int'(mb) + int'(mc);
        full  = total[WIDTH:0];
`ifdef SERIAL_ADD_OVF_EN
        v = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
`else
        v = 1'b0;
`endif
        return {v, full};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        chk("idle_wait", {63'd0, busy}, 64'd0);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        exp_q.push_back(model(ta, tb_v, tc));
        acc_q.push_back(cyc + 1);
        done_q.push_back(cyc + 1 + WIDTH);
        step();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (done_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_wait", 64'(done_q.size()), 64'd0);
    endtask

    // Monitor: checks busy/done every cycle, result on done, hold value while idle.
    always @(negedge clk) begin
        if (mon_en) begin : mon
            logic exp_busy;
            logic exp_done;
            logic [WIDTH+1:0] obs;
            exp_busy = (done_q.size() > 0) && (cyc >= acc_q[0]) && (cyc <= done_q[0]);
            exp_done = (done_q.size() > 0) && (cyc == done_q[0]);
            obs = {dut_ovf, cout, sum};
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            chk("done", {63'd0, done}, {63'd0, exp_done});
            if (exp_done) begin
                chk("result", 64'(obs), 64'(exp_q[0]));
                last_res = exp_q.pop_front();
                void'(acc_q.pop_front());
                void'(done_q.pop_front());
            end else if (!exp_busy) begin
                chk("hold", 64'(obs), 64'(last_res));
            end
        end
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", {63'd0, cout}, 64'd0);
        chk("reset_ovf", {63'd0, dut_ovf}, 64'd0);
        last_res = '0;
        mon_en   = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0);
        wait_idle();
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1);
        wait_idle();

        // Start during RUN must be ignored.
        do_op(8'h12, 8'h34, 1'b0);
        repeat (3) step();
        a = 8'h55; b = 8'h55; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();

        // Start in the done cycle must be dropped.
        do_op(8'hA5, 8'h3C, 1'b1);
        n = 0;
        while (done_q.size() > 0 && cyc != done_q[0] && n < 50) begin
            step();
            n++;
        end
        a = 8'hAA; b = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        repeat (4) step();

        // Reset in RUN cycle 4 abandons the addition.
        do_op(8'hC3, 8'h5A, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        done_q.delete();
        last_res = '0;
        repeat (2) step();
        do_op(8'h3C, 8'h42, 1'b0);
        wait_idle();

        // Signed overflow corners.
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h80, 8'h80, 1'b0);
        do_op(8'h10, 8'h20, 1'b0);
        wait_idle();

        for (int i = 0; i < 1000; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
